// File: rtl/uart_tx_pkg.sv
// Shared constants and state encoding for the UART transmit engine.
package uart_tx_pkg;

  // Default divisor width; matches the core data width.
  localparam int unsigned XLEN_DEF        = 32;

  // Fixed 8N1 framing: 1 start bit, 8 data bits and 1 stop bit.
  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_FRAME_BITS = 10;
  localparam int unsigned UART_IDX_W      = $clog2(UART_DATA_BITS);

  // Transmit FSM states.
  typedef enum logic [1:0] {
    UART_TX_IDLE  = 2'd0,
    UART_TX_START = 2'd1,
    UART_TX_DATA  = 2'd2,
    UART_TX_STOP  = 2'd3
  } uart_tx_state_e;

endpackage : uart_tx_pkg

// File: rtl/uart_tx_if.sv
// Connection between the UART register block (master) and the transmit engine (slave).
interface uart_tx_if
  import uart_tx_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) ();

  logic                      uart_en;
  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx_strt;
  logic [XLEN-1:0]           refclk_st;
  logic                      tx_busy;
  logic                      txd;

  // Register block side: drives control, reads back status and observes the line.
  modport master (
    output uart_en,
    output tx_data,
    output tx_strt,
    output refclk_st,
    input  tx_busy,
    input  txd
  );

  // Transmit engine side.
  modport slave (
    input  uart_en,
    input  tx_data,
    input  tx_strt,
    input  refclk_st,
    output tx_busy,
    output txd
  );

endinterface : uart_tx_if

// File: rtl/uart_tx_baud_gen.sv
// Bit-period timer: counts 0..divisor-1 while running and flags the last cycle of each bit.
module uart_tx_baud_gen
  import uart_tx_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            bit_tick_c_o
);

  logic [XLEN-1:0] cnt_q;
  logic [XLEN-1:0] cnt_d;
  logic            at_end;

  // Compare against divisor-1 so a full-range divisor never needs an extra counter bit.
  assign at_end       = (cnt_q == (divisor_i - XLEN'(1)));
  assign bit_tick_c_o = run_i && at_end;

  // Next count: held at zero while idle, wraps at the end of each bit period.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || at_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + XLEN'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : uart_tx_baud_gen

// File: rtl/uart_tx.sv
// UART transmit engine: sends one 8N1 frame, LSB first, per accepted start pulse.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  uart_tx_if.slave    tx_if
);

  uart_tx_state_e            state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_IDX_W-1:0]     idx_q,   idx_d;
  logic [XLEN-1:0]           div_q,   div_d;
  logic                      txd_q,   txd_d;
  logic                      busy_q,  busy_d;
  logic                      run_c;
  logic                      tick_c;

  // The bit timer only runs while a frame is on the wire.
  assign run_c = (state_q != UART_TX_IDLE);

  uart_tx_baud_gen #(
    .XLEN (XLEN)
  ) u_baud_gen (
    .clk          (clk),
    .rst          (rst),
    .run_i        (run_c),
    .divisor_i    (div_q),
    .bit_tick_c_o (tick_c)
  );

  // Next-state and output logic; disabling the UART overrides every other event.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    div_d   = div_q;
    txd_d   = txd_q;
    busy_d  = busy_q;

    if (!tx_if.uart_en) begin
      state_d = UART_TX_IDLE;
      txd_d   = 1'b1;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        UART_TX_IDLE: begin
          txd_d  = 1'b1;
          busy_d = 1'b0;
          if (tx_if.tx_strt) begin
            state_d = UART_TX_START;
            shift_d = tx_if.tx_data;
            // A zero divisor is treated as one cycle per bit.
            div_d   = (tx_if.refclk_st == '0) ? XLEN'(1) : tx_if.refclk_st;
            idx_d   = '0;
            txd_d   = 1'b0;
            busy_d  = 1'b1;
          end
        end
        UART_TX_START: begin
          if (tick_c) begin
            state_d = UART_TX_DATA;
            txd_d   = shift_q[0];
          end
        end
        UART_TX_DATA: begin
          if (tick_c) begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + UART_IDX_W'(1);
            if (idx_q == UART_IDX_W'(UART_DATA_BITS - 1)) begin
              state_d = UART_TX_STOP;
              txd_d   = 1'b1;
            end else begin
              txd_d   = shift_q[1];
            end
          end
        end
        UART_TX_STOP: begin
          if (tick_c) begin
            state_d = UART_TX_IDLE;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
          end
        end
        default: begin
          state_d = UART_TX_IDLE;
          txd_d   = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UART_TX_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      div_q   <= XLEN'(1);
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  assign tx_if.txd     = txd_q;
  assign tx_if.tx_busy = busy_q;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx against a per-cycle frame waveform model.
module tb_uart_tx;
  import uart_tx_pkg::*;

  localparam int unsigned XW = 32;

  logic clk = 1'b0;
  logic rst;

  uart_tx_if #(.XLEN(XW)) bus ();

  uart_tx #(.XLEN(XW)) dut (
    .clk   (clk),
    .rst   (rst),
    .tx_if (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected line level k cycles after the start edge of a frame with bit period d.
  function automatic logic model_txd(input logic [7:0] data, input int d, input int k);
    int b;
    if (k < 0) return 1'b1;
    b = k / d;
    if (b == 0) return 1'b0;
    if (b > int'(UART_DATA_BITS)) return 1'b1;
    return data[b-1];
  endfunction

  // Expected busy flag k cycles after the start edge.
  function automatic logic model_busy(input int d, input int k);
    return (k >= 0) && (k < int'(UART_FRAME_BITS) * d);
  endfunction

  function automatic int eff_div(input logic [XW-1:0] r);
    return (r == '0) ? 1 : int'(r);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a start pulse; returns one sample point after the start edge.
  task automatic launch(input logic [7:0] data, input logic [XW-1:0] div);
    bus.tx_data   = data;
    bus.refclk_st = div;
    bus.uart_en   = 1'b1;
    bus.tx_strt   = 1'b1;
    step();
    bus.tx_strt   = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.uart_en = 1'b1;
    bus.tx_strt = 1'b0;
    step();
    step();
    total++;
    if ({bus.txd, bus.tx_busy} !== 2'b10) begin
      bad++;
      $display("FAIL reset txd/busy got=%b%b want=10", bus.txd, bus.tx_busy);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if ({bus.txd, bus.tx_busy} !== 2'b10) begin
        bad++;
        $display("FAIL reset_idle k=%0d got=%b%b want=10", k, bus.txd, bus.tx_busy);
      end
    end
  endtask

  task automatic test_basic();
    launch(8'hA5, XW'(4));
    for (int k = 0; k < 45; k++) begin
      total++;
      if ({bus.txd, bus.tx_busy} !== {model_txd(8'hA5, 4, k), model_busy(4, k)}) begin
        bad++;
        $display("FAIL basic k=%0d got=%b%b want=%b%b", k, bus.txd, bus.tx_busy,
                 model_txd(8'hA5, 4, k), model_busy(4, k));
      end
      step();
    end
  endtask

  task automatic test_div01();
    for (int r = 0; r < 2; r++) begin
      launch(8'h00, XW'(r));
      for (int k = 0; k < 14; k++) begin
        total++;
        if ({bus.txd, bus.tx_busy} !== {model_txd(8'h00, eff_div(XW'(r)), k),
                                          model_busy(eff_div(XW'(r)), k)}) begin
          bad++;
          $display("FAIL div%0d k=%0d got=%b%b want=%b%b", r, k, bus.txd, bus.tx_busy,
                   model_txd(8'h00, 1, k), model_busy(1, k));
        end
        step();
      end
    end
  endtask

  // Start pulses mid-frame and in the final stop cycle, plus a divisor rewrite, must not disturb the frame.
  task automatic test_ignored();
    launch(8'h3C, XW'(4));
    for (int k = 0; k < 60; k++) begin
      total++;
      if ({bus.txd, bus.tx_busy} !== {model_txd(8'h3C, 4, k), model_busy(4, k)}) begin
        bad++;
        $display("FAIL ignored k=%0d got=%b%b want=%b%b", k, bus.txd, bus.tx_busy,
                 model_txd(8'h3C, 4, k), model_busy(4, k));
      end
      if (k == 5)  begin bus.tx_strt = 1'b1; bus.tx_data = 8'hFF; end
      if (k == 6)  bus.tx_strt = 1'b0;
      if (k == 10) bus.refclk_st = XW'(8);
      if (k == 39) bus.tx_strt = 1'b1;
      if (k == 40) bus.tx_strt = 1'b0;
      step();
    end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 3; it++) begin
      logic [7:0] d1v, d2v;
      int d1, d2, len1;
      d1v  = 8'($urandom);
      d2v  = 8'($urandom);
      d1   = int'($urandom_range(5, 1));
      d2   = int'($urandom_range(5, 1));
      len1 = int'(UART_FRAME_BITS) * d1;
      launch(d1v, XW'(d1));
      for (int k = 0; k < len1 + int'(UART_FRAME_BITS) * d2 + 3; k++) begin
        logic et, eb;
        if (k <= len1) begin
          et = model_txd(d1v, d1, k);
          eb = model_busy(d1, k);
        end else begin
          et = model_txd(d2v, d2, k - len1 - 1);
          eb = model_busy(d2, k - len1 - 1);
        end
        total++;
        if ({bus.txd, bus.tx_busy} !== {et, eb}) begin
          bad++;
          $display("FAIL b2b it=%0d k=%0d got=%b%b want=%b%b", it, k, bus.txd, bus.tx_busy, et, eb);
        end
        if (k == len1) begin
          bus.tx_data   = d2v;
          bus.refclk_st = XW'(d2);
          bus.tx_strt   = 1'b1;
        end
        if (k == len1 + 1) bus.tx_strt = 1'b0;
        step();
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] dv;
    dv = 8'($urandom);
    launch(dv, XW'(4));
    for (int k = 0; k < 24; k++) begin
      logic et, eb;
      et = (k <= 13) ? model_txd(dv, 4, k) : 1'b1;
      eb = (k <= 13) ? model_busy(4, k) : 1'b0;
      total++;
      if ({bus.txd, bus.tx_busy} !== {et, eb}) begin
        bad++;
        $display("FAIL abort k=%0d got=%b%b want=%b%b", k, bus.txd, bus.tx_busy, et, eb);
      end
      if (k == 13) bus.uart_en = 1'b0;
      step();
    end
    // Start while disabled is ignored.
    bus.tx_strt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if ({bus.txd, bus.tx_busy} !== 2'b10) begin
        bad++;
        $display("FAIL en_low_start k=%0d got=%b%b want=10", k, bus.txd, bus.tx_busy);
      end
    end
    bus.tx_strt = 1'b0;
    // Enable and start rise together: accepted, full clean frame.
    dv = 8'($urandom);
    launch(dv, XW'(4));
    for (int k = 0; k < 42; k++) begin
      total++;
      if ({bus.txd, bus.tx_busy} !== {model_txd(dv, 4, k), model_busy(4, k)}) begin
        bad++;
        $display("FAIL after_abort k=%0d got=%b%b want=%b%b", k, bus.txd, bus.tx_busy,
                 model_txd(dv, 4, k), model_busy(4, k));
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] dv;
    dv = 8'($urandom);
    launch(dv, XW'(3));
    for (int k = 0; k < 20; k++) begin
      logic et, eb;
      et = (k <= 10) ? model_txd(dv, 3, k) : 1'b1;
      eb = (k <= 10) ? model_busy(3, k) : 1'b0;
      total++;
      if ({bus.txd, bus.tx_busy} !== {et, eb}) begin
        bad++;
        $display("FAIL reset_mid k=%0d got=%b%b want=%b%b", k, bus.txd, bus.tx_busy, et, eb);
      end
      if (k == 10) rst = 1'b1;
      if (k == 11) rst = 1'b0;
      step();
    end
    dv = 8'($urandom);
    launch(dv, XW'(3));
    for (int k = 0; k < 32; k++) begin
      total++;
      if ({bus.txd, bus.tx_busy} !== {model_txd(dv, 3, k), model_busy(3, k)}) begin
        bad++;
        $display("FAIL after_reset k=%0d got=%b%b want=%b%b", k, bus.txd, bus.tx_busy,
                 model_txd(dv, 3, k), model_busy(3, k));
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [7:0] dv;
      int d, gap;
      dv  = 8'($urandom);
      d   = int'($urandom_range(7, 1));
      gap = int'($urandom_range(3, 0));
      repeat (gap) step();
      launch(dv, XW'(d));
      for (int k = 0; k < int'(UART_FRAME_BITS) * d + 2; k++) begin
        total++;
        if ({bus.txd, bus.tx_busy} !== {model_txd(dv, d, k), model_busy(d, k)}) begin
          bad++;
          $display("FAIL random it=%0d d=%0d k=%0d got=%b%b want=%b%b", it, d, k,
                   bus.txd, bus.tx_busy, model_txd(dv, d, k), model_busy(d, k));
        end
        step();
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.uart_en   = 1'b0;
    bus.tx_strt   = 1'b0;
    bus.tx_data   = 8'h00;
    bus.refclk_st = '0;
    test_reset();
    test_basic();
    test_div01();
    test_ignored();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_tx

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmit engine for the UART peripheral. It sits directly downstream of the UART register block.
- Consumes that block's uart_en, tx_reg, tx_strt and refclk_st outputs. Produces the tx_busy status the register block reads back, plus the serial TX pin.
- Frame format is fixed 8N1, LSB first. The bit period is programmable in clk cycles.

Parameters:
- XLEN, 32, width of the bit-period divisor (refclk_st); matches the core data width.

Ports:
- clk  input  1  global clock
- rst  input  1  reset; synchronous, active-high
- uart_en  input  1  UART enable; low forces idle
- tx_data  input  8  byte to send (from register tx_reg)
- tx_strt  input  1  one-cycle start pulse
- refclk_st  input  XLEN  bit period in clk cycles
- tx_busy  output  1  frame in progress
- txd  output  1  serial line, idle high

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset: txd=1, tx_busy=0, state IDLE, counters 0. Reset mid-frame aborts the frame at the next edge. No partial completion.
- States: IDLE, START, DATA, STOP. Outputs txd and tx_busy are registered.
- IDLE -> START on tx_strt=1 with uart_en=1 at edge N. At the same edge:
  - latch tx_data into shift register;
  - latch divisor D = (refclk_st==0) ? 1 : refclk_st;
  - txd<=0, tx_busy<=1, baud_cnt<=0, bit_idx<=0.
- Latched D and data are fixed for the whole frame. Writes to refclk_st or tx_data mid-frame affect only the next frame.
- Bit tick: baud_cnt counts 0..D-1 and wraps to 0. A tick occurs in the cycle where baud_cnt==D-1. Each bit therefore holds for exactly D cycles.
- START --tick--> DATA: txd<=shift[0].
- DATA: on each tick, shift right and increment bit_idx. On the tick with bit_idx==7 -> STOP, txd<=1.
- STOP --tick--> IDLE: tx_busy<=0, txd stays 1.
- Frame timing:
  - tx_busy is high for exactly 10*D cycles, from edge N+1 through edge N+10D.
  - txd sequence: 0, d0..d7, 1, each held for D cycles.
- tx_strt while tx_busy=1 (including the final STOP cycle) is ignored. No queueing; software polls tx_busy.
- tx_strt with uart_en=0 is ignored.
- uart_en falling in any state: next edge forces IDLE, txd=1, tx_busy=0. This abort has priority over tick and start.
- tx_strt and uart_en rise in the same cycle: start accepted.
- Counter width is XLEN. D up to 2^XLEN-1 must work with no overflow, because the comparison is against D-1.

Decomposition:
- Shared include (uart_general.vh, alongside core_general.vh, which supplies XLEN):
  - state encodings UART_TX_IDLE/START/DATA/STOP (2-bit localparams);
  - UART_DATA_BITS=8;
  - UART_FRAME_BITS=10.
- Sub-module uart_baud_gen:
  - inputs: clk, rst, run, divisor;
  - output: bit_tick;
  - counter clears when run=0.
- uart_tx holds the FSM, shift register, and output registers.

Test Plan:
- Basic frame: refclk_st=4, uart_en=1, tx_data=8'hA5, tx_strt pulse -> txd = 0 | 1,0,1,0,0,1,0,1 | 1, each held 4 cycles; tx_busy high exactly 40 cycles starting the edge after tx_strt.
- Divisor 0/1: refclk_st=0, then refclk_st=1, tx_data=8'h00 -> each bit lasts 1 cycle, tx_busy high 10 cycles, txd=0 for 9 cycles then 1.
- Ignored start and mid-frame writes: second tx_strt with tx_data=8'hFF at cycle 5 of an 8'h3C frame (D=4), and refclk_st changed to 8 mid-frame -> 8'h3C frame unchanged, still 40 cycles; no second frame follows.
- Back-to-back: tx_strt on the first cycle after tx_busy falls -> new frame starts; txd low on the next edge with no extra idle cycle.
- Abort: uart_en deasserted at cycle 13 of a D=4 frame -> next edge txd=1, tx_busy=0. A later tx_strt with uart_en=1 sends a clean full frame.
- Reset mid-frame: rst=1 for 1 cycle during DATA -> txd=1, tx_busy=0 at that edge; the FSM stays IDLE until the next tx_strt.
